// File: rtl/fu_issue_scheduler.sv
// Multi-issue scheduler: matches ready RS entries to free FU issue slots each cycle.
// Define FU_SCHED_RR_EN for round-robin priority; otherwise fixed priority with RS0 highest.
module fu_issue_scheduler #(
  parameter int NUM_RS = 4,
  parameter int NUM_FU = 4,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 3,
  parameter int XLEN   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_RS-1:0]        rs_valid,
  input  logic [NUM_RS*NUM_FU-1:0] rs_fu_mask,
  input  logic [NUM_RS*ROB_W-1:0]  rs_rob,
  input  logic [NUM_RS*OP_W-1:0]   rs_op,
  input  logic [NUM_RS*2-1:0]      rs_branch_type,
  input  logic [NUM_RS*XLEN-1:0]   rs_src1,
  input  logic [NUM_RS*XLEN-1:0]   rs_src2,
  output logic [NUM_RS-1:0]        rs_consumed,
  input  logic [NUM_FU-1:0]        fu_ready,
  output logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU*ROB_W-1:0]  fu_rob,
  output logic [NUM_FU*OP_W-1:0]   fu_op,
  output logic [NUM_FU*2-1:0]      fu_branch_type,
  output logic [NUM_FU*XLEN-1:0]   fu_src1,
  output logic [NUM_FU*XLEN-1:0]   fu_src2
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_FU-1:0]        slot_free;
  logic [NUM_FU-1:0]        grant;
  logic [NUM_RS-1:0]        taken;
  logic [NUM_FU*ROB_W-1:0]  ld_rob;
  logic [NUM_FU*OP_W-1:0]   ld_op;
  logic [NUM_FU*2-1:0]      ld_bt;
  logic [NUM_FU*XLEN-1:0]   ld_src1;
  logic [NUM_FU*XLEN-1:0]   ld_src2;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         rr_next;
  logic                     any_grant;

  // A slot can accept a new instruction when empty or when its current one transfers now
  assign slot_free   = ~fu_valid | fu_ready;
  assign rs_consumed = taken;

  always_comb begin : alloc
    int best_k;
    int best_r;
    int k;
    int first_k;
    int nxt;
    taken     = '0;
    grant     = '0;
    ld_rob    = '0;
    ld_op     = '0;
    ld_bt     = '0;
    ld_src1   = '0;
    ld_src2   = '0;
    rr_next   = rr_ptr;
    any_grant = 1'b0;
    best_k    = NUM_RS;
    best_r    = 0;
    k         = 0;
    first_k   = NUM_RS;
    nxt       = 0;
    if (!reset && !flush) begin
      for (int f = 0; f < NUM_FU; f++) begin
        best_k = NUM_RS;
        best_r = 0;
        if (slot_free[f]) begin
          // Pick the eligible entry closest to rr_ptr in rotating priority order
          for (int r = 0; r < NUM_RS; r++) begin
            k = r - int'(rr_ptr);
            if (k < 0) k = k + NUM_RS;
            if (rs_valid[r] && rs_fu_mask[r*NUM_FU+f] && !taken[r] && (k < best_k)) begin
              best_k = k;
              best_r = r;
            end
          end
          if (best_k < NUM_RS) begin
            grant[f] = 1'b1;
            if (best_k < first_k) first_k = best_k;
            for (int r = 0; r < NUM_RS; r++) begin
              if (r == best_r) begin
                taken[r] = 1'b1;
                ld_rob[f*ROB_W +: ROB_W] = rs_rob[r*ROB_W +: ROB_W];
                ld_op[f*OP_W +: OP_W]    = rs_op[r*OP_W +: OP_W];
                ld_bt[f*2 +: 2]          = rs_branch_type[r*2 +: 2];
                ld_src1[f*XLEN +: XLEN]  = rs_src1[r*XLEN +: XLEN];
                ld_src2[f*XLEN +: XLEN]  = rs_src2[r*XLEN +: XLEN];
              end
            end
          end
        end
      end
    end
    any_grant = |grant;
    if (any_grant) begin
      nxt = int'(rr_ptr) + first_k + 1;
      if (nxt >= NUM_RS) nxt = nxt - NUM_RS;
      rr_next = PTR_W'(nxt);
    end
  end

  // Issue slot registers: load on grant, drain when transferred, hold while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fu_valid       <= '0;
      fu_rob         <= '0;
      fu_op          <= '0;
      fu_branch_type <= '0;
      fu_src1        <= '0;
      fu_src2        <= '0;
    end else begin
      for (int f = 0; f < NUM_FU; f++) begin
        if (flush) begin
          fu_valid[f] <= 1'b0;
        end else if (grant[f]) begin
          fu_valid[f]                 <= 1'b1;
          fu_rob[f*ROB_W +: ROB_W]    <= ld_rob[f*ROB_W +: ROB_W];
          fu_op[f*OP_W +: OP_W]       <= ld_op[f*OP_W +: OP_W];
          fu_branch_type[f*2 +: 2]    <= ld_bt[f*2 +: 2];
          fu_src1[f*XLEN +: XLEN]     <= ld_src1[f*XLEN +: XLEN];
          fu_src2[f*XLEN +: XLEN]     <= ld_src2[f*XLEN +: XLEN];
        end else if (slot_free[f]) begin
          fu_valid[f] <= 1'b0;
        end
      end
    end
  end

`ifdef FU_SCHED_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= rr_next;
    end
  end
`else
  logic unused_rr;
  assign rr_ptr    = '0;
  assign unused_rr = ^{rr_next, any_grant};
`endif

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Scoreboard bench for fu_issue_scheduler: directed vectors push expectations, a monitor pops and compares.
module tb_fu_issue_scheduler;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [3:0]  rs_valid;
  logic [15:0] rs_fu_mask;
  logic [15:0] rs_rob;
  logic [11:0] rs_op;
  logic [7:0]  rs_branch_type;
  logic [127:0] rs_src1;
  logic [127:0] rs_src2;
  logic [3:0]  rs_consumed;
  logic [3:0]  fu_ready;
  logic [3:0]  fu_valid;
  logic [15:0] fu_rob;
  logic [11:0] fu_op;
  logic [7:0]  fu_branch_type;
  logic [127:0] fu_src1;
  logic [127:0] fu_src2;

  typedef struct {
    int          slot;
    logic [3:0]  rob;
    logic [2:0]  op;
    logic [1:0]  bt;
    logic [31:0] s1;
    logic [31:0] s2;
  } pay_t;

  typedef struct {
    logic [3:0] cons;
    logic [3:0] fuv;
  } exp_t;

  exp_t exp_q[$];
  pay_t pay_q[$];
  int   checks = 0;
  int   errors = 0;

  fu_issue_scheduler dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rs_valid(rs_valid), .rs_fu_mask(rs_fu_mask), .rs_rob(rs_rob), .rs_op(rs_op),
    .rs_branch_type(rs_branch_type), .rs_src1(rs_src1), .rs_src2(rs_src2),
    .rs_consumed(rs_consumed), .fu_ready(fu_ready), .fu_valid(fu_valid),
    .fu_rob(fu_rob), .fu_op(fu_op), .fu_branch_type(fu_branch_type),
    .fu_src1(fu_src1), .fu_src2(fu_src2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pay_t mkPay(int seed, int r, int slot);
    pay_t p;
    p.slot = slot;
    p.rob  = 4'(seed * 3 + r);
    p.op   = 3'(seed + r);
    p.bt   = 2'(seed + r + 1);
    p.s1   = {8'(seed), 8'hA5, 8'(r), 8'h11};
    p.s2   = {8'(r), 8'(seed), 16'hBEEF};
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drivePayload(input int seed);
    pay_t p;
    for (int r = 0; r < 4; r++) begin
      p = mkPay(seed, r, 0);
      rs_rob[r*4 +: 4]         = p.rob;
      rs_op[r*3 +: 3]          = p.op;
      rs_branch_type[r*2 +: 2] = p.bt;
      rs_src1[r*32 +: 32]      = p.s1;
      rs_src2[r*32 +: 32]      = p.s2;
    end
  endtask

  // g0..g3: entry expected to be granted into slot f this cycle, -1 for none
  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] m, input logic [3:0] rdy,
                               input logic fl, input int seed, input logic [3:0] ec,
                               input logic [3:0] ev, input int g0, input int g1,
                               input int g2, input int g3);
    exp_t e;
    int   g[4];
    @(posedge clk);
    #1;
    rs_valid   = v;
    rs_fu_mask = m;
    fu_ready   = rdy;
    flush      = fl;
    drivePayload(seed);
    e.cons = ec;
    e.fuv  = ev;
    exp_q.push_back(e);
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    for (int f = 0; f < 4; f++)
      if (g[f] >= 0) pay_q.push_back(mkPay(seed, g[f], f));
  endtask

  // Monitor: per-cycle grant/valid check plus payload check of every occupied slot
  always @(negedge clk) begin : monitor
    exp_t e;
    pay_t p;
    int   idx;
    if (!reset) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rs_consumed", 32'(rs_consumed), 32'(e.cons));
        checkOutput("fu_valid", 32'(fu_valid), 32'(e.fuv));
      end
      for (int f = 0; f < 4; f++) begin
        if (fu_valid[f]) begin
          idx = -1;
          for (int i = 0; i < pay_q.size(); i++)
            if (idx < 0 && pay_q[i].slot == f) idx = i;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL slot_payload slot %0d actual=valid required=no pending instruction", f);
          end else begin
            p = pay_q[idx];
            checkOutput("fu_rob", 32'(fu_rob[f*4 +: 4]), 32'(p.rob));
            checkOutput("fu_op", 32'(fu_op[f*3 +: 3]), 32'(p.op));
            checkOutput("fu_branch_type", 32'(fu_branch_type[f*2 +: 2]), 32'(p.bt));
            checkOutput("fu_src1", fu_src1[f*32 +: 32], p.s1);
            checkOutput("fu_src2", fu_src2[f*32 +: 32], p.s2);
            if (fu_ready[f]) pay_q.delete(idx);
          end
        end
      end
      if (flush) pay_q.delete();
    end
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    rs_valid = 4'hF;
    rs_fu_mask = 16'h8421;
    fu_ready = 4'hF;
    drivePayload(0);
    #12;
    checkOutput("reset_fu_valid", 32'(fu_valid), 32'h0);
    checkOutput("reset_consumed", 32'(rs_consumed), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rs_valid = 4'h0;

    // Contention: entries 0 and 2 both want FU1 only
    applyStimulus(4'b0101, 16'h0202, 4'hF, 1'b0, 1, 4'b0001, 4'b0000, -1, 0, -1, -1);
`ifdef FU_SCHED_RR_EN
    applyStimulus(4'b0101, 16'h0202, 4'hF, 1'b0, 2, 4'b0100, 4'b0010, -1, 2, -1, -1);
`else
    applyStimulus(4'b0101, 16'h0202, 4'hF, 1'b0, 2, 4'b0001, 4'b0010, -1, 0, -1, -1);
`endif
    applyStimulus(4'b0000, 16'h0000, 4'hF, 1'b0, 3, 4'b0000, 4'b0010, -1, -1, -1, -1);

    // Parallel issue, one FU per entry
    applyStimulus(4'b1111, 16'h8421, 4'hF, 1'b0, 4, 4'b1111, 4'b0000, 0, 1, 2, 3);

    // Stall slot 3 while entry 1 waits for FU3
    applyStimulus(4'b0000, 16'h0000, 4'b0111, 1'b0, 5, 4'b0000, 4'b1111, -1, -1, -1, -1);
    for (int i = 0; i < 3; i++)
      applyStimulus(4'b0010, 16'h0080, 4'b0111, 1'b0, 6 + i, 4'b0000, 4'b1000, -1, -1, -1, -1);
    applyStimulus(4'b0010, 16'h0080, 4'hF, 1'b0, 9, 4'b0010, 4'b1000, -1, -1, -1, 1);
    applyStimulus(4'b0000, 16'h0000, 4'hF, 1'b0, 10, 4'b0000, 4'b1000, -1, -1, -1, -1);

    // Flush with stalled occupied slots and eligible free slots
    applyStimulus(4'b0011, 16'h8421, 4'hF, 1'b0, 11, 4'b0011, 4'b0000, 0, 1, -1, -1);
    applyStimulus(4'b0011, 16'h0084, 4'h0, 1'b1, 12, 4'b0000, 4'b0011, -1, -1, -1, -1);
    applyStimulus(4'b0000, 16'h0000, 4'hF, 1'b0, 13, 4'b0000, 4'b0000, -1, -1, -1, -1);

    // Entry 2 has an empty mask; entry 0 keeps issuing to FU2
    for (int i = 0; i < 10; i++)
      applyStimulus(4'b0101, 16'h0004, 4'hF, 1'b0, 14 + i, 4'b0001,
                    (i == 0) ? 4'b0000 : 4'b0100, -1, -1, 0, -1);
    applyStimulus(4'b0000, 16'h0000, 4'hF, 1'b0, 24, 4'b0000, 4'b0100, -1, -1, -1, -1);

    // Two entries eligible on every FU: slot order follows priority order
`ifdef FU_SCHED_RR_EN
    applyStimulus(4'b0011, 16'h00FF, 4'hF, 1'b0, 25, 4'b0011, 4'b0000, 1, 0, -1, -1);
`else
    applyStimulus(4'b0011, 16'h00FF, 4'hF, 1'b0, 25, 4'b0011, 4'b0000, 0, 1, -1, -1);
`endif
    applyStimulus(4'b0000, 16'h0000, 4'hF, 1'b0, 26, 4'b0000, 4'b0011, -1, -1, -1, -1);

    // Fill all slots, stall them, then reset mid-cycle
    applyStimulus(4'b1111, 16'h8421, 4'hF, 1'b0, 27, 4'b1111, 4'b0000, 0, 1, 2, 3);
    applyStimulus(4'b0000, 16'h0000, 4'h0, 1'b0, 28, 4'b0000, 4'b1111, -1, -1, -1, -1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    rs_valid = 4'hF;
    rs_fu_mask = 16'h8421;
    fu_ready = 4'hF;
    #1;
    checkOutput("midreset_fu_valid", 32'(fu_valid), 32'h0);
    checkOutput("midreset_consumed", 32'(rs_consumed), 32'h0);
    pay_q.delete();
    @(negedge clk);
    reset = 1'b0;
    rs_valid = 4'h0;
    applyStimulus(4'b0000, 16'h0000, 4'hF, 1'b0, 29, 4'b0000, 4'b0000, -1, -1, -1, -1);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("pending_vectors", 32'(exp_q.size()), 32'h0);
    checkOutput("pending_payloads", 32'(pay_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_issue_scheduler.md
Name: fu_issue_scheduler

Overview:
Multi-issue scheduler in the Execute stage. Each cycle it matches ready reservation-station (RS) entries to free functional units (FUs), grants up to NUM_FU issues, and returns a consumed pulse to each granted RS entry. Each FU receives its payload from a registered valid/ready output slot. The block generalises single-issue, fixed-priority selection to parametrised RS/FU counts, per-entry FU eligibility masks, optional round-robin fairness, and flush.

Parameters:
NUM_RS, 4, number of RS entries presented.
NUM_FU, 4, number of functional units / issue slots.
ROB_W, 4, ROB tag width.
OP_W, 3, ALU opcode width.
XLEN, 32, operand width.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
flush  input  1  squash: clear all issue slots, no grants this cycle
rs_valid  input  NUM_RS  entry r holds valid, operand-ready instruction
rs_fu_mask  input  NUM_RS*NUM_FU  bit [r*NUM_FU+f]=1: entry r may execute on FU f
rs_rob  input  NUM_RS*ROB_W  ROB tag per entry
rs_op  input  NUM_RS*OP_W  opcode per entry
rs_branch_type  input  NUM_RS*2  branch type per entry
rs_src1, rs_src2  input  NUM_RS*XLEN  operands per entry
rs_consumed  output  NUM_RS  combinational grant; RS frees entry at next edge
fu_ready  input  NUM_FU  FU f accepts slot f this cycle
fu_valid  output  NUM_FU  slot f holds an instruction
fu_rob  output  NUM_FU*ROB_W  slot payload
fu_op  output  NUM_FU*OP_W  slot payload
fu_branch_type  output  NUM_FU*2  slot payload
fu_src1, fu_src2  output  NUM_FU*XLEN  slot payload

Behaviour:
- Reset (async): fu_valid=0, all payload regs=0, rr_ptr=0; rs_consumed=0 while reset is high.
- Slot f is "free" when fu_valid[f]==0, or fu_valid[f]&&fu_ready[f] (transfer this cycle).
- Allocation (combinational), FU index order f=0..NUM_FU-1: slot f takes the highest-priority entry r with rs_valid[r] && mask bit (r,f) set && r not already granted to a lower f. No entry is granted twice. A free slot with no candidate loads nothing.
- Priority order: starts at rr_ptr and increments mod NUM_RS (see Optional Feature).
- rs_consumed[r]=1 in the same cycle as r's grant. Exactly one cycle per grant, because the RS drops rs_valid[r] after the edge.
- Edge: granted slot loads payload, fu_valid[f]=1. A free slot not granted clears to fu_valid[f]=0. A non-free slot holds its payload unchanged (stall; outputs stable while fu_valid&&!fu_ready).
- Latency: rs_valid→fu_valid is 1 cycle. Sustained throughput is 1 issue per FU per cycle.
- Entry with all-zero mask: never granted, never consumed; no error.
- flush=1: rs_consumed=0; all fu_valid cleared at edge regardless of fu_ready; rr_ptr unchanged. flush has priority over grants.
- reset mid-transfer: slot content lost, no consumed pulse emitted.
- Payload X-free: ungranted slots keep prior payload (no X assignment).

Optional Feature:
FU_SCHED_RR_EN. Defined: after any cycle with ≥1 grant, rr_ptr ← (index of first-granted entry in priority order + 1) mod NUM_RS. With no grants, rr_ptr holds. Undefined: rr_ptr is tied to 0 and the register is removed, giving fixed priority with RS0 highest.

Test Plan:
- Reset: assert reset mid-cycle with fu_valid=4'b1111 → fu_valid=0 immediately, rs_consumed=0.
- Parallel issue: rs_valid=4'b1111, each entry masks only FU r, fu_ready=4'b1111 → rs_consumed=4'b1111; next cycle fu_valid=4'b1111, fu_rob[f]=rs_rob[f].
- Contention: entries 0 and 2 both mask only FU1, rr_ptr=0 → entry 0 granted, rs_consumed=4'b0001. Next cycle with FU_SCHED_RR_EN, rr_ptr=1, so entry 2 wins. Without the macro, entry 0 wins again if it is re-presented.
- Stall: fu_valid[3]=1, fu_ready[3]=0 for 3 cycles, entry 1 masks only FU3 → no grant, fu_* slot 3 unchanged. When fu_ready[3]=1, entry 1 is granted that cycle and loaded next cycle.
- Flush: rs_valid=4'b0011 with eligible free slots, flush=1 → rs_consumed=0; next cycle fu_valid=0.
- Zero mask: rs_valid[2]=1, mask=0 for 10 cycles → rs_consumed[2] never asserts; other entries issue normally.
